// File: rtl/host_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// host_pkg : register offsets and controller state encoding for host_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package host_pkg;

   localparam int c_win_regs = 8;
   localparam int c_idx_w    = 3;

   localparam logic [c_idx_w-1:0] c_off_halt      = 3'd0;
   localparam logic [c_idx_w-1:0] c_off_sig_begin = 3'd1;
   localparam logic [c_idx_w-1:0] c_off_sig_end   = 3'd2;
   localparam logic [c_idx_w-1:0] c_off_tx        = 3'd3;
   localparam logic [c_idx_w-1:0] c_off_cycle     = 3'd4;

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_DRAIN = 3'd1,
      ST_DREQ  = 3'd2,
      ST_DOUT  = 3'd3,
      ST_DONE  = 3'd4
   } host_state_t;

endpackage
`default_nettype wire

// File: rtl/host_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// host_fifo : synchronous FIFO with occupancy count and same-cycle push/pop
// Rev 1.0
// ---------------------------------------------------------------------------
module host_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == (c_aw+1)'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO still accepts a byte when a slot frees in the same cycle
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/host_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// host_ctrl : memory-mapped halt/console/cycle controller with signature dump
// Rev 1.0
// ---------------------------------------------------------------------------
module host_ctrl
   import host_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = 'h2000_0000,
   parameter int              TX_DEPTH  = 16,
   parameter int              TIMEOUT   = 0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            store,
   input  logic            load,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] store_data,
   output logic            hit,
   output logic [XLEN-1:0] rdata,
   output logic            cpu_stall,
   output logic            tx_valid,
   output logic [7:0]      tx_data,
   input  logic            tx_ready,
   output logic [XLEN-1:0] mem_raddr,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            dump_valid,
   output logic [XLEN-1:0] dump_data,
   output logic            dump_last,
   input  logic            dump_ready,
   output logic            done,
   output logic            timed_out,
   output logic [XLEN-2:0] exit_code
);

   localparam int              c_bytes     = XLEN / 8;
   localparam int              c_align     = $clog2(c_bytes);
   localparam int              c_cw        = $clog2(TX_DEPTH) + 1;
   localparam logic [XLEN-1:0] c_win_bytes = XLEN'(c_win_regs * c_bytes);
   localparam logic [XLEN-1:0] c_step      = XLEN'(c_bytes);

   host_state_t      r_state;
   host_state_t      w_state_nxt;
   logic [XLEN-1:0]  w_off;
   logic [c_idx_w-1:0] w_idx;
   logic [XLEN-1:0]  w_sig_d;
   logic             w_wr;
   logic             w_halt_wr;
   logic             w_timeout;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_empty;
   logic [c_cw-1:0]  w_count;
   logic [c_cw-1:0]  w_free;
   logic [XLEN-1:0]  w_rd_val;
   logic             w_last;

   logic [XLEN-2:0]  r_exit_code;
   logic             r_timed_out;
   logic [XLEN-1:0]  r_sig_begin;
   logic [XLEN-1:0]  r_sig_end;
   logic [XLEN-1:0]  r_ptr;
   logic [XLEN-1:0]  r_cap;
   logic             r_first;
   logic [XLEN-1:0]  r_cycle;
   logic [31:0]      r_run_cnt;
   logic [XLEN-1:0]  r_rdata;

   assign w_off     = address - BASE_ADDR;
   assign hit       = (w_off < c_win_bytes);
   assign w_idx     = w_off[c_align +: c_idx_w];
   assign w_sig_d   = {store_data[XLEN-1:c_align], {c_align{1'b0}}};
   assign w_wr      = store && hit && (r_state == ST_RUN);
   assign w_halt_wr = w_wr && (w_idx == c_off_halt) && store_data[0];
   assign w_timeout = (TIMEOUT != 0) && (r_state == ST_RUN) &&
                      (r_run_cnt == 32'(TIMEOUT - 1)) && !w_halt_wr;
   assign w_push    = w_wr && (w_idx == c_off_tx);
   assign w_pop     = tx_valid && tx_ready;
   assign w_free    = c_cw'(TX_DEPTH) - w_count;
   assign w_last    = ((r_ptr + c_step) == r_sig_end);

   host_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_data  (store_data[7:0]),
      .i_pop   (w_pop),
      .o_data  (tx_data),
      .o_empty (w_fifo_empty),
      .o_count (w_count)
   );

   assign tx_valid = !w_fifo_empty;

   always_comb begin
      w_rd_val = '0;
      case (w_idx)
         c_off_halt:  w_rd_val = {{(XLEN-1){1'b0}}, (r_state != ST_RUN)};
         c_off_tx:    w_rd_val = {{(XLEN-c_cw){1'b0}}, w_free};
         c_off_cycle: w_rd_val = r_cycle;
         default:     w_rd_val = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_raddr   = '0;
      dump_valid  = 1'b0;
      dump_data   = '0;
      dump_last   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_halt_wr || w_timeout) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_fifo_empty) w_state_nxt = (r_sig_end > r_sig_begin) ? ST_DREQ : ST_DONE;
         end
         ST_DREQ: begin
            mem_raddr   = r_ptr;
            w_state_nxt = ST_DOUT;
         end
         ST_DOUT: begin
            // RAM data is live only on the first DOUT cycle; later cycles replay the capture
            dump_valid = 1'b1;
            dump_data  = r_first ? mem_rdata : r_cap;
            dump_last  = w_last;
            if (dump_ready) w_state_nxt = w_last ? ST_DONE : ST_DREQ;
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_exit_code <= '0;
         r_timed_out <= 1'b0;
         r_sig_begin <= '0;
         r_sig_end   <= '0;
         r_ptr       <= '0;
         r_cap       <= '0;
         r_first     <= 1'b0;
         r_cycle     <= '0;
         r_run_cnt   <= '0;
         r_rdata     <= '0;
      end else begin
         r_cycle <= r_cycle + 1'b1;
         r_first <= (r_state == ST_DREQ);
         if (r_state == ST_RUN) r_run_cnt <= r_run_cnt + 1'b1;
         if (w_halt_wr) begin
            r_exit_code <= store_data[XLEN-1:1];
         end else if (w_timeout) begin
            r_exit_code <= '1;
            r_timed_out <= 1'b1;
         end
         if (w_wr && (w_idx == c_off_sig_begin)) r_sig_begin <= w_sig_d;
         if (w_wr && (w_idx == c_off_sig_end))   r_sig_end   <= w_sig_d;
         if (r_state == ST_DRAIN)
            r_ptr <= r_sig_begin;
         else if ((r_state == ST_DOUT) && dump_ready && !w_last)
            r_ptr <= r_ptr + c_step;
         if ((r_state == ST_DOUT) && r_first) r_cap <= mem_rdata;
         r_rdata <= (load && hit) ? w_rd_val : '0;
      end
   end

   assign rdata     = r_rdata;
   assign cpu_stall = (r_state != ST_RUN);
   assign done      = (r_state == ST_DONE);
   assign timed_out = r_timed_out;
   assign exit_code = r_exit_code;

endmodule
`default_nettype wire

// File: tb/tb_host_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_host_ctrl : randomized self-checking bench for host_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_host_ctrl;

   localparam logic [31:0] c_base = 32'h2000_0000;

   logic        clock;
   logic        reset;
   logic        store;
   logic        load;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        tx_ready;
   logic        dump_ready;
   logic [31:0] mem_rdata;

   logic        hit, cpu_stall, tx_valid, dump_valid, dump_last, done, timed_out;
   logic [31:0] rdata, mem_raddr, dump_data;
   logic [7:0]  tx_data;
   logic [30:0] exit_code;

   logic        to_hit, to_cpu_stall, to_tx_valid, to_dump_valid, to_dump_last, to_done, to_timed_out;
   logic [31:0] to_rdata, to_mem_raddr, to_dump_data;
   logic [7:0]  to_tx_data;
   logic [30:0] to_exit_code;

   logic [31:0] ram [0:1023];
   logic [7:0]  txq[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] dq[$];
   logic        lq[$];
   int          rdy_mode;
   logic        prev_stall;
   logic [31:0] prev_data;
   logic        prev_last;
   logic        to_dv_seen;
   int          n_chk;
   int          n_err;

   host_ctrl #(.XLEN(32), .BASE_ADDR(c_base), .TX_DEPTH(16), .TIMEOUT(0)) u_dut (
      .clock(clock), .reset(reset), .store(store), .load(load), .address(address),
      .store_data(store_data), .hit(hit), .rdata(rdata), .cpu_stall(cpu_stall),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_data(dump_data),
      .dump_last(dump_last), .dump_ready(dump_ready), .done(done), .timed_out(timed_out),
      .exit_code(exit_code)
   );

   host_ctrl #(.XLEN(32), .BASE_ADDR(c_base), .TX_DEPTH(16), .TIMEOUT(50)) u_to (
      .clock(clock), .reset(reset), .store(1'b0), .load(1'b0), .address(32'h0),
      .store_data(32'h0), .hit(to_hit), .rdata(to_rdata), .cpu_stall(to_cpu_stall),
      .tx_valid(to_tx_valid), .tx_data(to_tx_data), .tx_ready(1'b1), .mem_raddr(to_mem_raddr),
      .mem_rdata(32'h0), .dump_valid(to_dump_valid), .dump_data(to_dump_data),
      .dump_last(to_dump_last), .dump_ready(1'b1), .done(to_done), .timed_out(to_timed_out),
      .exit_code(to_exit_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) mem_rdata <= ram[mem_raddr[11:2]];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Sinks and stream monitor: ready is driven on the falling edge, sampled 1 ns later
   always begin
      @(negedge clock);
      dump_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (reset) begin
         if (prev_stall) begin
            chk("hold_valid", dump_valid, 1);
            chk("hold_data", dump_data, prev_data);
            chk("hold_last", dump_last, prev_last);
         end
         prev_stall = dump_valid && !dump_ready;
         prev_data  = dump_data;
         prev_last  = dump_last;
         if (dump_valid && dump_ready) begin
            dq.push_back(dump_data);
            lq.push_back(dump_last);
         end
         if (tx_valid && tx_ready) txq.push_back(tx_data);
         if (to_dump_valid) to_dv_seen = 1'b1;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic logic [31:0] ra(input int idx);
      return c_base + 32'(idx * 4);
   endfunction

   task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
      store = 1'b1; address = addr; store_data = data;
      @(negedge clock);
      store = 1'b0; address = '0; store_data = '0;
   endtask

   task automatic cpu_load(input logic [31:0] addr, output logic [31:0] v);
      load = 1'b1; address = addr;
      @(negedge clock);
      load = 1'b0; address = '0;
      v = rdata;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      txq.delete(); dq.delete(); lq.delete(); exp_tx.delete();
   endtask

   task automatic wait_done(input int lim);
      for (int i = 0; i < lim && !done; i++) @(negedge clock);
      chk("done", done, 1);
   endtask

   task automatic check_tx(input string tag);
      chk({tag, "_cnt"}, 64'(txq.size()), 64'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size(); i++)
         chk({tag, "_byte"}, (i < txq.size()) ? 64'(txq[i]) : 64'hBAD, 64'(exp_tx[i]));
   endtask

   task automatic check_dump(input string tag, input logic [31:0] base, input int nw);
      chk({tag, "_cnt"}, 64'(dq.size()), 64'(nw));
      for (int i = 0; i < nw; i++) begin
         chk({tag, "_word"}, (i < dq.size()) ? 64'(dq[i]) : 64'hBAD,
             64'(ram[(base >> 2) + 32'(i)]));
         chk({tag, "_last"}, (i < lq.size()) ? 64'(lq[i]) : 64'hBAD, 64'(i == nw - 1));
      end
   endtask

   initial begin
      logic [31:0] v, v1, b, base, halt_v;
      int          nw;
      n_chk = 0; n_err = 0; rdy_mode = 0; to_dv_seen = 1'b0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      store = 0; load = 0; address = 0; store_data = 0; tx_ready = 0; dump_ready = 1;
      for (int i = 0; i < 1024; i++) ram[i] = $urandom;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_done", done, 0);
      chk("rst_txv", tx_valid, 0);
      chk("rst_dv", dump_valid, 0);
      chk("rst_exit", exit_code, 0);
      chk("rst_to", timed_out, 0);
      chk("rst_rdata", rdata, 0);
      reset = 1'b1;

      // Timeout instance: 50 cycles in RUN, then empty signature range goes straight to DONE
      repeat (49) @(negedge clock);
      chk("to_early", to_timed_out, 0);
      @(negedge clock);
      chk("to_flag", to_timed_out, 1);
      chk("to_exit", to_exit_code, 31'h7FFF_FFFF);
      chk("to_stall", to_cpu_stall, 1);
      for (int i = 0; i < 10 && !to_done; i++) @(negedge clock);
      chk("to_done", to_done, 1);
      chk("to_no_dump", to_dv_seen, 0);

      // Console "Hi"
      do_reset();
      tx_ready = 1'b1;
      exp_tx.push_back(8'h48); exp_tx.push_back(8'h69);
      cpu_store(ra(3), 32'h48);
      cpu_store(ra(3), 32'h69);
      repeat (4) @(negedge clock);
      check_tx("hi");

      // Random bytes with stalling sink, never exceeding capacity
      txq.delete(); exp_tx.delete();
      nw = $urandom_range(4, 16);
      for (int i = 0; i < nw; i++) begin
         b = $urandom;
         exp_tx.push_back(b[7:0]);
         tx_ready = 1'($urandom_range(0, 1));
         cpu_store(ra(3), b);
      end
      tx_ready = 1'b1;
      repeat (20) @(negedge clock);
      check_tx("rtx");

      // Window decode, unmapped offsets, even halt, cycle counter
      address = c_base + 32'h1C; #1 chk("hit_top", hit, 1);
      address = c_base + 32'h20; #1 chk("hit_above", hit, 0);
      address = c_base - 32'h4;  #1 chk("hit_below", hit, 0);
      address = '0;
      @(negedge clock);
      cpu_store(ra(5), 32'hFFFF_FFFF);
      cpu_load(ra(5), v);  chk("unmapped_rd", v, 0);
      cpu_store(ra(0), 32'h2);
      cpu_load(ra(0), v);  chk("halt_even", v, 0);
      chk("halt_even_stall", cpu_stall, 0);
      cpu_load(ra(4), v1);
      repeat (5) @(negedge clock);
      cpu_load(ra(4), v);  chk("cycle_delta", v - v1, 6);
      cpu_load(ra(3), v);  chk("free_empty", v, 16);

      // Overflow: 16 held, 17th dropped, full push succeeds alongside a pop
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         b = $urandom;
         if (i < 16) exp_tx.push_back(b[7:0]);
         cpu_store(ra(3), b);
      end
      cpu_load(ra(3), v);  chk("free_full", v, 0);
      b = $urandom;
      exp_tx.push_back(b[7:0]);
      tx_ready = 1'b1;
      cpu_store(ra(3), b);
      repeat (20) @(negedge clock);
      check_tx("ovf");
      cpu_load(ra(3), v);  chk("free_after", v, 16);

      // Signature dumps: fixed case first, then random ranges with random back-pressure
      for (int it = 0; it < 4; it++) begin
         do_reset();
         rdy_mode = (it == 0) ? 0 : 1;
         base   = (it == 0) ? 32'h100 : 32'h100 + 32'($urandom_range(0, 64)) * 4;
         nw     = (it == 0) ? 3 : $urandom_range(1, 8);
         halt_v = (it == 0) ? 32'h1 : ($urandom | 32'h1);
         cpu_store(ra(1), (it == 0) ? base : base | 32'($urandom_range(0, 3)));
         cpu_store(ra(2), base + 32'(nw * 4) + ((it == 0) ? 32'h0 : 32'($urandom_range(0, 3))));
         cpu_store(ra(0), halt_v);
         wait_done(200);
         chk("dump_exit", exit_code, halt_v >> 1);
         check_dump("dump", base, nw);
         cpu_load(ra(0), v);  chk("halted_rd", v, 1);
      end
      rdy_mode = 0;

      // Halt waits for the console to drain; writes after halt are ignored
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b = $urandom;
         exp_tx.push_back(b[7:0]);
         cpu_store(ra(3), b);
      end
      cpu_store(ra(1), 32'h200);
      cpu_store(ra(2), 32'h208);
      cpu_store(ra(0), 32'h7);
      cpu_store(ra(2), 32'h300);
      repeat (10) @(negedge clock);
      chk("drain_stall", cpu_stall, 1);
      chk("drain_nodump", 64'(dq.size()), 0);
      chk("drain_notdone", done, 0);
      chk("drain_txv", tx_valid, 1);
      tx_ready = 1'b1;
      wait_done(100);
      check_tx("drain");
      check_dump("drain_dump", 32'h200, 2);
      chk("drain_exit", exit_code, 3);

      // Asynchronous reset while a word is held in DOUT
      do_reset();
      rdy_mode = 2;
      cpu_store(ra(1), 32'h100);
      cpu_store(ra(2), 32'h110);
      cpu_store(ra(0), 32'h11);
      for (int i = 0; i < 50 && !dump_valid; i++) @(negedge clock);
      chk("mid_dout", dump_valid, 1);
      chk("mid_exit", exit_code, 8);
      reset = 1'b0;
      #1;
      chk("arst_dv", dump_valid, 0);
      chk("arst_last", dump_last, 0);
      chk("arst_data", dump_data, 0);
      chk("arst_stall", cpu_stall, 0);
      chk("arst_exit", exit_code, 0);
      chk("arst_raddr", mem_raddr, 0);
      @(negedge clock);
      reset = 1'b1;
      rdy_mode = 0;
      repeat (2) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
